reg_file: RTL and testbench

- ARMv8 integer register file for the decode stage: 32 general registers X0..X31, each 64 bits wide.
- Two independent read ports feed operands Rn and Rm to the datapath.
- One write port takes the result Rd from writeback.
- X31 is the zero register (XZR).

---
 rtl/reg_file.sv | 76 +++++++
 tb/tb_reg_file.sv | 138 +++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: 32 x 64-bit integer register file with two combinational read
// ports, one write port, and X31 hardwired as the zero register.
//
// Ports:
//   clk        - rising-edge clock for all state updates
//   rst        - synchronous active-high reset; clears every register
//   regWrite   - write enable for the write port
//   read_reg1  - read port 1 index (Rn)
//   read_reg2  - read port 2 index (Rm)
//   write_reg  - write port index (Rd)
//   write_data - data written to register[write_reg]
//   read_data1 - contents of register[read_reg1], with write-through forwarding
//   read_data2 - contents of register[read_reg2], with write-through forwarding
module reg_file #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // A write that actually lands this cycle; writes to the zero register are dropped.
  logic wr_en_c;
  assign wr_en_c = regWrite && !rst && (write_reg != ZERO_IDX);

  // Next-state: only the addressed register changes on a valid write.
  always_comb begin
    regs_d = regs_q;
    if (wr_en_c) begin
      regs_d[write_reg] = write_data;
    end
  end

  // State register with synchronous reset; reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read mux: zero register first, then same-cycle write-through, then storage.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] idx);
    logic [DATA_WIDTH-1:0] val;
    val = regs_q[idx];
    if (idx == ZERO_IDX) begin
      val = '0;
    end else if (wr_en_c && (write_reg == idx)) begin
      val = write_data;
    end
    return val;
  endfunction

  always_comb begin
    read_data1 = read_port(read_reg1);
    read_data2 = read_port(read_reg2);
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed, table-driven check of reg_file. Each vector drives
// inputs on the falling edge, checks both read ports just before the next
// rising edge, then lets that edge commit any write or reset.
module tb_reg_file;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 5;
  localparam int unsigned CYCLE = 10;
  localparam int unsigned NVEC  = 13;

  logic          clk;
  logic          rst;
  logic          regWrite;
  logic [AW-1:0] read_reg1;
  logic [AW-1:0] read_reg2;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;

  int checks;
  int failures;

  reg_file #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .ZERO_REG  (31)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .regWrite  (regWrite),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .write_reg (write_reg),
    .write_data(write_data),
    .read_data1(read_data1),
    .read_data2(read_data2)
  );

  initial clk = 1'b0;
  always #(CYCLE / 2) clk = ~clk;

  typedef struct {
    logic          rst;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    @(negedge clk);
    rst        = r;
    regWrite   = we;
    write_reg  = wa;
    write_data = wd;
    read_reg1  = r1;
    read_reg2  = r2;
    #1;
  endtask

  initial begin
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    checks   = 0;
    failures = 0;

    // Columns: rst, we, wa, wd, r1, r2, expected rd1, expected rd2 (before the edge)
    vecs[0]  = '{1'b0, 1'b0, 5'd0,  64'd0,                  5'd10, 5'd15, 64'd0,                  64'd0};
    vecs[1]  = '{1'b0, 1'b1, 5'd9,  64'd256,                5'd9,  5'd10, 64'd256,                64'd0};
    vecs[2]  = '{1'b0, 1'b0, 5'd9,  64'd0,                  5'd9,  5'd10, 64'd256,                64'd0};
    vecs[3]  = '{1'b0, 1'b1, 5'd5,  64'hDEAD_BEEF_0000_0001, 5'd9,  5'd5,  64'd256,                64'hDEAD_BEEF_0000_0001};
    vecs[4]  = '{1'b0, 1'b0, 5'd5,  64'd0,                  5'd5,  5'd5,  64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001};
    vecs[5]  = '{1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd9,  64'd0,                  64'd256};
    vecs[6]  = '{1'b0, 1'b0, 5'd31, 64'd0,                  5'd31, 5'd31, 64'd0,                  64'd0};
    vecs[7]  = '{1'b0, 1'b0, 5'd9,  64'd7,                  5'd9,  5'd5,  64'd256,                64'hDEAD_BEEF_0000_0001};
    vecs[8]  = '{1'b0, 1'b0, 5'd9,  64'd7,                  5'd9,  5'd9,  64'd256,                64'd256};
    vecs[9]  = '{1'b0, 1'b1, 5'd12, 64'h1234_5678_9ABC_DEF0, 5'd12, 5'd12, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0};
    // Reset with a colliding write: no forwarding, storage still visible until the edge.
    vecs[10] = '{1'b1, 1'b1, 5'd3,  64'd99,                 5'd3,  5'd9,  64'd0,                  64'd256};
    vecs[11] = '{1'b0, 1'b0, 5'd0,  64'd0,                  5'd3,  5'd9,  64'd0,                  64'd0};
    vecs[12] = '{1'b0, 1'b0, 5'd0,  64'd0,                  5'd5,  5'd12, 64'd0,                  64'd0};

    // Initial reset with a junk write pending; reset must win.
    drive(1'b1, 1'b1, 5'd7, 64'hAAAA_5555_AAAA_5555, 5'd7, 5'd31);
    drive(1'b1, 1'b0, 5'd0, 64'd0, 5'd7, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd7, 5'd0);
    check("reset_rd1_x7", read_data1, 64'd0);
    check("reset_rd2_x0", read_data2, 64'd0);

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].r1, vecs[i].r2);
      check($sformatf("vec%0d_rd1", i), read_data1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), read_data2, vecs[i].e2);
    end

    // Sweep every writable index: forwarded value during the write on port 1.
    for (int i = 0; i < 31; i++) begin
      drive(1'b0, 1'b1, AW'(i), DW'(i * 3), AW'(i), 5'd31);
      check($sformatf("sweep_fwd%0d", i), read_data1, DW'(i * 3));
    end

    // Read back on both ports with different indices per port.
    for (int i = 0; i < 31; i++) begin
      drive(1'b0, 1'b0, 5'd0, 64'd0, AW'(i), AW'(30 - i));
      e1 = DW'(i * 3);
      e2 = DW'((30 - i) * 3);
      check($sformatf("sweep_rd1_%0d", i), read_data1, e1);
      check($sformatf("sweep_rd2_%0d", i), read_data2, e2);
    end

    // Zero register still reads 0 after the sweep and a further write attempt.
    drive(1'b0, 1'b1, 5'd31, 64'h0123_4567_89AB_CDEF, 5'd31, 5'd30);
    check("xzr_during_write", read_data1, 64'd0);
    check("x30_unaffected", read_data2, 64'd90);
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd31, 5'd31);
    check("xzr_after_write", read_data1, 64'd0);
    check("xzr_after_write_p2", read_data2, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
